uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s; BIT_CYC = CLK_FREQ/BAUD (integer division), HALF = BIT_CYC/2.
REQ-003 clk  input  1  single system clock, all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 d_rx  output  8  received byte, stable while vld_rx=1.
REQ-007 vld_rx  output  1  byte available in output register.
REQ-008 rdy_rx  input  1  consumer ready; transfer occurs on any cycle with vld_rx=1 and rdy_rx=1.
REQ-009 frm_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 ovr_err  output  1  one-cycle pulse, new byte dropped because output register still occupied.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_HI.
REQ-013 IDLE: rxs=0 -> START, baud counter cleared; otherwise stay.
REQ-014 START: after HALF cycles sample rxs; 0 -> DATA with bit counter 0; 1 -> IDLE (glitch rejected, no output, no error).
REQ-015 DATA: every BIT_CYC cycles sample rxs into shift register LSB first; after 8th sample -> STOP.
REQ-016 STOP: after BIT_CYC cycles sample rxs; 1 -> deliver byte, -> IDLE; 0 -> discard byte, pulse frm_err, -> WAIT_HI.
REQ-017 WAIT_HI: stay until rxs=1, then -> IDLE.
REQ-018 Delivery: on the stop-sample cycle, if output register empty or being transferred that same cycle, d_rx loads the byte and vld_rx=1 from the next cycle.
REQ-019 Delivery with vld_rx=1 and rdy_rx=0 that cycle: new byte dropped, d_rx/vld_rx unchanged, ovr_err pulses one cycle.
REQ-020 vld_rx SHALL remain high, d_rx unchanged, until a transfer cycle; after transfer vld_rx=0 next cycle unless REQ-018 reloads simultaneously.
REQ-021 vld_rx SHALL not depend combinationally on rdy_rx.
REQ-022 Baud counter width = clog2(BIT_CYC)+1; counter restarts at 0 at each sample point; no free-running phase.
REQ-023 Receiver SHALL accept back-to-back frames: new start bit detectable from the first IDLE cycle after stop sample.

Reset
REQ-024 rst=1 on a clock edge: state IDLE, counters 0, shift register 0, d_rx=8'h00, vld_rx=0, frm_err=0, ovr_err=0.
REQ-025 Synchronizer flops reset to 1 (idle line), so a low rxd during reset is seen as a start edge only after release.
REQ-026 Reset mid-frame SHALL abandon the frame with no output or error pulse.

Structure
REQ-027 Package uart_pkg SHALL hold CLK_FREQ/BAUD defaults, BIT_CYC/HALF derivation and the FSM state encoding, shared with the transmitter.
REQ-028 One sub-module, bit_sync (2-flop synchronizer, reset value parameter); all other logic in uart_rx.

Verification (CLK_FREQ=16, BAUD=1, BIT_CYC=16)
REQ-029 Frame 0x55, rdy_rx=1 held -> d_rx=8'h55, vld_rx high exactly 1 cycle, no error pulses.
REQ-030 rxd low 4 cycles then high -> no vld_rx, no frm_err, FSM back to IDLE.
REQ-031 Frame 0xA3 with stop bit low -> frm_err one pulse, vld_rx stays 0; rxd held low 40 more cycles -> no new frame until rxd high.
REQ-032 Frames 0x31 then 0x0D back-to-back, rdy_rx=0 -> d_rx=8'h31 held, ovr_err one pulse at 2nd stop sample; then rdy_rx=1 -> 8'h31 transferred, vld_rx=0.
REQ-033 rdy_rx=1 on exactly the stop-sample cycle of 2nd frame with 0x31 pending -> 0x31 transferred, d_rx=8'h0D, vld_rx stays 1, no ovr_err.
REQ-034 rst asserted during DATA bit 3 of 0x7E -> vld_rx=0, no pulses; following frame 0x41 received correctly as 8'h41.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line timing, bit-period derivation and
// the receiver/transmitter FSM state encoding.
package uart_pkg;

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } uart_state_t;

    // Clock cycles per bit period (integer division).
    function automatic int bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clock cycles from start-bit edge to start-bit midpoint.
    function automatic int half_cyc(input int clk_freq, input int baud);
        return bit_cyc(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input with a
// configurable reset value.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at mid-bit, LSB-first data
// sampling, stop-bit check and a single-entry output register with
// valid/ready handshake, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] d_rx,
    output logic       vld_rx,
    input  logic       rdy_rx,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
    localparam int HALF    = half_cyc(CLK_FREQ, BAUD);
    localparam int CW      = $clog2(BIT_CYC) + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic          rxs;
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    // Idle line is high, so a low rxd held through reset only starts a
    // frame once the synchronizer has propagated it after release.
    bit_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    // Receive FSM, baud/bit counters, shift register and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            d_rx    <= '0;
            vld_rx  <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so later lines in
            // this block may override earlier defaults (pulse clear, vld_rx
            // drop) without any ordering hazard against other flops.
            frm_err <= 1'b0;
            ovr_err <= 1'b0;

            // A transfer empties the output register unless a delivery
            // below reloads it in the same cycle.
            if (vld_rx && rdy_rx) begin
                vld_rx <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            if (!vld_rx || rdy_rx) begin
                                d_rx   <= shreg;
                                vld_rx <= 1'b1;
                            end else begin
                                ovr_err <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= ST_WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WAIT_HI: begin
                    cnt <= '0;
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit,
// expected bytes are queued at stimulus time and a monitor pops and
// compares them on every valid/ready transfer.
module tb_uart_rx;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    // Stop-bit sample cycle inside the stop bit: 2 sync flops + 1 idle
    // detect + HALF + 9 bit periods after the start edge, i.e. edge 155,
    // which is the 11th edge (index 10) of the stop bit.
    localparam int STOP_SAMPLE_IDX = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rdy_rx = 1'b0;
    logic [7:0] d_rx;
    logic       vld_rx;
    logic       frm_err;
    logic       ovr_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int vld_cycles = 0;
    int frm_pulses = 0;
    int ovr_pulses = 0;
    bit rand_rdy   = 1'b0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .d_rx    (d_rx),
        .vld_rx  (vld_rx),
        .rdy_rx  (rdy_rx),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after the drivers have updated inputs.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (vld_rx)  vld_cycles++;
                if (frm_err) frm_pulses++;
                if (ovr_err) ovr_pulses++;
                if (vld_rx && rdy_rx) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", d_rx);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("rx_byte", {24'd0, d_rx}, {24'd0, exp_b});
                    end
                end
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) rdy_rx = 1'($urandom_range(0, 1));
        end
    end

    // Global watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit rdy_at_stop);
        rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = stop;
        for (int k = 0; k < BIT_CYC; k++) begin
            if (rdy_at_stop) rdy_rx = (k == STOP_SAMPLE_IDX);
            @(negedge clk);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int v0, f0, o0;
        logic [7:0] rb;

        // Reset state.
        repeat (3) @(negedge clk);
        #2;
        check("rst_d_rx", {24'd0, d_rx}, 32'h00);
        check("rst_vld_rx", {31'd0, vld_rx}, 0);
        check("rst_frm_err", {31'd0, frm_err}, 0);
        check("rst_ovr_err", {31'd0, ovr_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(5);

        // Single frame 0x55 with consumer always ready.
        v0 = vld_cycles; f0 = frm_pulses; o0 = ovr_pulses;
        rdy_rx = 1'b1;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(20);
        drain(100);
        check("x55_vld_cycles", vld_cycles - v0, 1);
        check("x55_frm", frm_pulses - f0, 0);
        check("x55_ovr", ovr_pulses - o0, 0);

        // Short glitch on the line is rejected.
        v0 = vld_cycles; f0 = frm_pulses;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_vld", vld_cycles - v0, 0);
        check("glitch_frm", frm_pulses - f0, 0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 1'b0);
        idle(20);
        drain(100);

        // Framing error, then line held low: no new frame until high.
        v0 = vld_cycles; f0 = frm_pulses;
        send_frame(8'hA3, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        check("frm_pulse", frm_pulses - f0, 1);
        check("frm_no_vld", vld_cycles - v0, 0);
        idle(20);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(20);
        drain(100);
        check("frm_after_recover", frm_pulses - f0, 1);

        // Overrun: two frames with consumer stalled.
        o0 = ovr_pulses; f0 = frm_pulses;
        rdy_rx = 1'b0;
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1, 1'b0);
        send_frame(8'h0D, 1'b1, 1'b0);
        idle(20);
        #2;
        check("ovr_d_rx_held", {24'd0, d_rx}, 32'h31);
        check("ovr_vld_held", {31'd0, vld_rx}, 1);
        check("ovr_pulse", ovr_pulses - o0, 1);
        check("ovr_no_frm", frm_pulses - f0, 0);
        @(negedge clk);
        rdy_rx = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("ovr_vld_cleared", {31'd0, vld_rx}, 0);
        drain(20);

        // Transfer coinciding with the second stop sample: no overrun.
        o0 = ovr_pulses;
        rdy_rx = 1'b0;
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1, 1'b0);
        exp_q.push_back(8'h0D);
        send_frame(8'h0D, 1'b1, 1'b1);
        idle(5);
        #2;
        check("coincide_d_rx", {24'd0, d_rx}, 32'h0D);
        check("coincide_vld", {31'd0, vld_rx}, 1);
        check("coincide_no_ovr", ovr_pulses - o0, 0);
        check("coincide_pending", exp_q.size(), 1);
        @(negedge clk);
        rdy_rx = 1'b1;
        drain(20);

        // Reset during data bit 3 of 0x7E abandons the frame.
        v0 = vld_cycles; f0 = frm_pulses; o0 = ovr_pulses;
        rb = 8'h7E;
        rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = rb[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = rb[3];
        repeat (BIT_CYC / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(40);
        #2;
        check("midrst_vld", {31'd0, vld_rx}, 0);
        check("midrst_d_rx", {24'd0, d_rx}, 32'h00);
        check("midrst_vld_cycles", vld_cycles - v0, 0);
        check("midrst_pulses", (frm_pulses - f0) + (ovr_pulses - o0), 0);
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1'b0);
        idle(20);
        drain(100);
        #2;
        check("midrst_next_d_rx", {24'd0, d_rx}, 32'h41);

        // Random bytes, random gaps (including back-to-back), random ready.
        f0 = frm_pulses; o0 = ovr_pulses;
        rand_rdy = 1'b1;
        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom);
            exp_q.push_back(rb);
            send_frame(rb, 1'b1, 1'b0);
            idle($urandom_range(0, 8));
        end
        idle(30);
        rand_rdy = 1'b0;
        @(negedge clk);
        rdy_rx = 1'b1;
        drain(200);
        check("rand_frm", frm_pulses - f0, 0);
        check("rand_ovr", ovr_pulses - o0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
